// File: rtl/fads_pkg.sv
// Shared definitions for the FADS droplet sorter: FSM encoding, register map
// offsets and reset defaults for the configuration registers.
package fads_pkg;

    // Upper bound on the number of evaluated ADC channels.
    localparam int unsigned ChnMax = 4;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDroplet   = 3'd1,
        StEval      = 3'd2,
        StSortDelay = 3'd3,
        StSortPulse = 3'd4
    } state_e;

    // Register offsets within the 20-bit decoded bus window.
    localparam logic [19:0] AddrCtrl     = 20'h00000;
    localparam logic [19:0] AddrNoise    = 20'h00004;
    localparam logic [19:0] AddrWmin     = 20'h00008;
    localparam logic [19:0] AddrWmax     = 20'h0000C;
    localparam logic [19:0] AddrDelay    = 20'h00010;
    localparam logic [19:0] AddrLen      = 20'h00014;
    localparam logic [19:0] AddrDropCnt  = 20'h00018;
    localparam logic [19:0] AddrPosCnt   = 20'h0001C;
    localparam logic [19:0] AddrMissCnt  = 20'h00020;
    localparam logic [19:0] AddrLastW    = 20'h00024;
    localparam logic [19:0] AddrStatus   = 20'h00028;
    localparam logic [19:0] AddrLastTs   = 20'h0002C;
    localparam logic [19:0] AddrSortTs   = 20'h00030;
    localparam logic [19:0] AddrLowBase  = 20'h00040;
    localparam logic [19:0] AddrHighBase = 20'h00044;
    localparam logic [19:0] AddrPeakBase = 20'h00080;

    // Reset defaults.
    localparam int NoiseThrDef = 15;
    localparam int LowThrDef   = 15;
    localparam int HighThrDef  = 255;
    localparam int LenDef      = 1000;

endpackage

// File: rtl/fads_peak_tracker.sv
// Signed running maximum of one ADC channel across a droplet.
// load_i restarts the maximum from the current sample; en_i folds in a new sample.
module fads_peak_tracker
    import fads_pkg::*;
#(
    parameter int unsigned DWT = 14
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           en_i,
    input  logic [DWT-1:0] sample_i,
    output logic [DWT-1:0] peak_o
);

    logic [DWT-1:0] peak_d, peak_q;

    // Next maximum: load wins over compare-and-update.
    always_comb begin
        peak_d = peak_q;
        if (load_i) begin
            peak_d = sample_i;
        end else if (en_i && ($signed(sample_i) > $signed(peak_q))) begin
            peak_d = sample_i;
        end
    end

    // Peak register, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/fads_droplet_sorter.sv
// Multi-channel FADS droplet sorter: gate detection on channel 0, per-channel peak
// tracking, window classification, delayed fixed-length sort pulse, and a bus
// register file with event counters.
// Optional build macro FADS_TIMESTAMP_EN adds a free-running cycle counter captured
// at each evaluation and at each sort pulse start.
module fads_droplet_sorter
    import fads_pkg::*;
#(
    parameter int unsigned CHN = 2,
    parameter int unsigned DWT = 14,
    parameter int unsigned MEM = 32
) (
    input  logic               adc_clk_i,
    input  logic               adc_rst_i,
    input  logic [CHN*DWT-1:0] adc_dat_i,
    output logic               sort_trig_o,
    output logic               sort_busy_o,
    output logic               droplet_o,
    input  logic [31:0]        sys_addr,
    input  logic [31:0]        sys_wdata,
    input  logic [3:0]         sys_sel,
    input  logic               sys_wen,
    input  logic               sys_ren,
    output logic [31:0]        sys_rdata,
    output logic               sys_err,
    output logic               sys_ack
);

    logic [19:0]    addr;
    logic           unused_bus;
    logic [DWT-1:0] sample [CHN];
    logic [DWT-1:0] peak   [CHN];

    // Configuration registers
    logic           enable_d, enable_q;
    logic [CHN-1:0] mask_d, mask_q;
    logic [DWT-1:0] noise_d, noise_q;
    logic [MEM-1:0] wmin_d, wmin_q, wmax_d, wmax_q, delay_d, delay_q, len_d, len_q;
    logic [DWT-1:0] low_d  [CHN];
    logic [DWT-1:0] low_q  [CHN];
    logic [DWT-1:0] high_d [CHN];
    logic [DWT-1:0] high_q [CHN];

    // Detection state
    state_e         state_d, state_q;
    logic [MEM-1:0] width_d, width_q, timer_d, timer_q, len_eff;
    logic           gate, gate_q, trk_load, trk_en, positive, in_eval, clr;

    // Counters and last-droplet capture
    logic [MEM-1:0] drop_cnt_d, drop_cnt_q, pos_cnt_d, pos_cnt_q, miss_cnt_d, miss_cnt_q;
    logic [MEM-1:0] last_w_d, last_w_q;
    logic [DWT-1:0] last_peak_d [CHN];
    logic [DWT-1:0] last_peak_q [CHN];

    // Bus response
    logic [31:0]    rdata_d, rdata_q;
    logic           ack_q;

    assign addr       = sys_addr[19:0];
    assign unused_bus = ^{sys_sel, sys_addr[31:20]};
    assign clr        = sys_wen && (addr == AddrCtrl) && sys_wdata[1];
    assign gate       = enable_q && ($signed(sample[0]) > $signed(noise_q));
    assign in_eval    = (state_q == StEval) && enable_q;
    assign len_eff    = (len_q == '0) ? MEM'(1) : len_q;

    for (genvar k = 0; k < CHN; k++) begin : g_chan
        assign sample[k] = adc_dat_i[k*DWT +: DWT];

        fads_peak_tracker #(
            .DWT (DWT)
        ) u_peak (
            .clk_i    (adc_clk_i),
            .rst_i    (adc_rst_i),
            .load_i   (trk_load),
            .en_i     (trk_en),
            .sample_i (sample[k]),
            .peak_o   (peak[k])
        );
    end

    // Configuration register writes; full-word, visible the cycle after sys_wen.
    always_comb begin
        enable_d = enable_q;
        mask_d   = mask_q;
        noise_d  = noise_q;
        wmin_d   = wmin_q;
        wmax_d   = wmax_q;
        delay_d  = delay_q;
        len_d    = len_q;
        low_d    = low_q;
        high_d   = high_q;
        if (sys_wen) begin
            case (addr)
                AddrCtrl: begin
                    enable_d = sys_wdata[0];
                    mask_d   = sys_wdata[8 +: CHN];
                end
                AddrNoise: noise_d = sys_wdata[DWT-1:0];
                AddrWmin:  wmin_d  = MEM'(sys_wdata);
                AddrWmax:  wmax_d  = MEM'(sys_wdata);
                AddrDelay: delay_d = MEM'(sys_wdata);
                AddrLen:   len_d   = MEM'(sys_wdata);
                default: begin
                    for (int k = 0; k < CHN; k++) begin
                        if (addr == AddrLowBase + 20'(8 * k)) begin
                            low_d[k] = sys_wdata[DWT-1:0];
                        end
                        if (addr == AddrHighBase + 20'(8 * k)) begin
                            high_d[k] = sys_wdata[DWT-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Classification of the droplet just ended: width window plus masked peak windows.
    always_comb begin
        positive = (width_q >= wmin_q) && (width_q <= wmax_q);
        for (int k = 0; k < CHN; k++) begin
            if (mask_q[k] && (($signed(peak[k]) < $signed(low_q[k])) ||
                              ($signed(peak[k]) > $signed(high_q[k])))) begin
                positive = 1'b0;
            end
        end
    end

    // Detection FSM next state; a cleared enable overrides everything.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        timer_d  = timer_q;
        trk_load = 1'b0;
        trk_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gate) begin
                    state_d  = StDroplet;
                    width_d  = MEM'(1);
                    trk_load = 1'b1;
                end
            end
            StDroplet: begin
                if (gate) begin
                    trk_en = 1'b1;
                    if (width_q != {MEM{1'b1}}) begin
                        width_d = width_q + MEM'(1);
                    end
                end else begin
                    state_d = StEval;
                end
            end
            StEval: begin
                timer_d = '0;
                if (!positive) begin
                    state_d = StIdle;
                end else if (delay_q == '0) begin
                    state_d = StSortPulse;
                end else begin
                    state_d = StSortDelay;
                end
            end
            StSortDelay: begin
                timer_d = timer_q + MEM'(1);
                // Compare against timer+1 so a delay shrunk mid-wait still terminates.
                if ((timer_q + MEM'(1)) >= delay_q) begin
                    state_d = StSortPulse;
                    timer_d = '0;
                end
            end
            StSortPulse: begin
                timer_d = timer_q + MEM'(1);
                if ((timer_q + MEM'(1)) >= len_eff) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable_q) begin
            state_d = StIdle;
        end
    end

    // Event counters and last-droplet capture; a clear write beats an increment.
    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        pos_cnt_d   = pos_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        last_w_d    = last_w_q;
        last_peak_d = last_peak_q;
        if (in_eval) begin
            drop_cnt_d = drop_cnt_q + MEM'(1);
            last_w_d   = width_q;
            for (int k = 0; k < CHN; k++) begin
                last_peak_d[k] = peak[k];
            end
            if (positive) begin
                pos_cnt_d = pos_cnt_q + MEM'(1);
            end
        end
        if (((state_q == StSortDelay) || (state_q == StSortPulse)) && gate && !gate_q) begin
            miss_cnt_d = miss_cnt_q + MEM'(1);
        end
        if (clr) begin
            drop_cnt_d = '0;
            pos_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

`ifdef FADS_TIMESTAMP_EN
    logic [MEM-1:0] ts_d, ts_q, last_ts_d, last_ts_q, sort_ts_d, sort_ts_q;

    // Free-running timestamp and its capture points.
    always_comb begin
        ts_d      = clr ? '0 : ts_q + MEM'(1);
        last_ts_d = in_eval ? ts_q : last_ts_q;
        sort_ts_d = ((state_d == StSortPulse) && (state_q != StSortPulse)) ? ts_q : sort_ts_q;
    end

    // Timestamp registers.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ts_q      <= '0;
            last_ts_q <= '0;
            sort_ts_q <= '0;
        end else begin
            ts_q      <= ts_d;
            last_ts_q <= last_ts_d;
            sort_ts_q <= sort_ts_d;
        end
    end
`endif

    // Read data mux; unmapped and out-of-range channel addresses return 0.
    always_comb begin
        rdata_d = '0;
        case (addr)
            AddrCtrl: begin
                rdata_d[0]         = enable_q;
                rdata_d[8 +: CHN]  = mask_q;
            end
            AddrNoise:   rdata_d = 32'($signed(noise_q));
            AddrWmin:    rdata_d = 32'(wmin_q);
            AddrWmax:    rdata_d = 32'(wmax_q);
            AddrDelay:   rdata_d = 32'(delay_q);
            AddrLen:     rdata_d = 32'(len_q);
            AddrDropCnt: rdata_d = 32'(drop_cnt_q);
            AddrPosCnt:  rdata_d = 32'(pos_cnt_q);
            AddrMissCnt: rdata_d = 32'(miss_cnt_q);
            AddrLastW:   rdata_d = 32'(last_w_q);
            AddrStatus:  rdata_d[2:0] = state_q;
`ifdef FADS_TIMESTAMP_EN
            AddrLastTs:  rdata_d = 32'(last_ts_q);
            AddrSortTs:  rdata_d = 32'(sort_ts_q);
`endif
            default: begin
                for (int k = 0; k < CHN; k++) begin
                    if (addr == AddrLowBase + 20'(8 * k)) begin
                        rdata_d = 32'($signed(low_q[k]));
                    end
                    if (addr == AddrHighBase + 20'(8 * k)) begin
                        rdata_d = 32'($signed(high_q[k]));
                    end
                    if (addr == AddrPeakBase + 20'(4 * k)) begin
                        rdata_d = 32'($signed(last_peak_q[k]));
                    end
                end
            end
        endcase
    end

    // State registers, synchronous active-high reset.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            enable_q   <= 1'b0;
            mask_q     <= '1;
            noise_q    <= DWT'(NoiseThrDef);
            wmin_q     <= '0;
            wmax_q     <= '1;
            delay_q    <= '0;
            len_q      <= MEM'(LenDef);
            for (int k = 0; k < CHN; k++) begin
                low_q[k]       <= DWT'(LowThrDef);
                high_q[k]      <= DWT'(HighThrDef);
                last_peak_q[k] <= '0;
            end
            state_q    <= StIdle;
            width_q    <= '0;
            timer_q    <= '0;
            gate_q     <= 1'b0;
            drop_cnt_q <= '0;
            pos_cnt_q  <= '0;
            miss_cnt_q <= '0;
            last_w_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            mask_q      <= mask_d;
            noise_q     <= noise_d;
            wmin_q      <= wmin_d;
            wmax_q      <= wmax_d;
            delay_q     <= delay_d;
            len_q       <= len_d;
            low_q       <= low_d;
            high_q      <= high_d;
            last_peak_q <= last_peak_d;
            state_q     <= state_d;
            width_q     <= width_d;
            timer_q     <= timer_d;
            gate_q      <= gate;
            drop_cnt_q  <= drop_cnt_d;
            pos_cnt_q   <= pos_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            last_w_q    <= last_w_d;
            rdata_q     <= rdata_d;
            ack_q       <= sys_wen | sys_ren;
        end
    end

    assign sort_trig_o = (state_q == StSortPulse);
    assign sort_busy_o = (state_q == StSortDelay) || (state_q == StSortPulse);
    assign droplet_o   = (state_q == StDroplet);
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

endmodule

// File: doc/fads_droplet_sorter.md
Name: fads_droplet_sorter

Overview:
Multi-channel successor to the single-channel FADS sorter.
- Detects droplets on a gate channel and tracks per-channel peak intensity and droplet width.
- Classifies each droplet against per-channel intensity windows and a global width window.
- Emits a delayed, fixed-length sort pulse to the ASG/HV trigger path, with counters and configuration on the Red Pitaya system bus.

Parameters:
- CHN, 2, number of ADC channels evaluated (1..4); channel 0 is the gate channel.
- DWT, 14, signed ADC sample and intensity-threshold width.
- MEM, 32, width of timers, counters and timing registers.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rst_i  in  1  reset, synchronous, active-high.
- adc_dat_i  in  CHN*DWT  signed samples; channel k is at [k*DWT +: DWT].
- sort_trig_o  out  1  sort pulse to ASG trigger.
- sort_busy_o  out  1  high from the start of SORT_DELAY through the last SORT_PULSE cycle.
- droplet_o  out  1  high while in DROPLET state.
- sys_addr  in  32  bus address.
- sys_wdata  in  32  bus write data.
- sys_sel  in  4  byte select; ignored, writes are full-word.
- sys_wen  in  1  bus write enable.
- sys_ren  in  1  bus read enable.
- sys_rdata  out  32  bus read data.
- sys_err  out  1  bus error; always 0.
- sys_ack  out  1  bus acknowledge.

Behaviour:
Reset:
- adc_rst_i is sampled on the adc_clk_i edge, synchronous, active-high. Reset has priority over everything.
- All outputs 0; FSM to IDLE; all counters, timers and peaks 0.
- Register defaults: enable=0, mask=all ones, noise thr=15, low thr=15, high thr=255, wmin=0, wmax=all ones, delay=0, len=1000.

Detection and classification:
- Gate condition: enable && ch0 > noise_thr, signed compare.
- FSM:
  - IDLE: on gate, go to DROPLET; width=1; peak[k]=sample[k].
  - DROPLET: while gate holds, width += 1 (saturating at 2^MEM-1) and peak[k] = max(peak[k], sample[k]). When gate drops, go to EVAL.
  - EVAL (one cycle): positive = (wmin <= width <= wmax) && for every masked k, (low[k] <= peak[k] <= high[k]). Increment droplet_cnt. If positive, increment positive_cnt and go to SORT_DELAY; otherwise go to IDLE. Latch width and peaks into the last_* registers.
  - SORT_DELAY: counts delay cycles; delay=0 skips directly to SORT_PULSE.
  - SORT_PULSE: sort_trig_o=1 for exactly len cycles; len=0 is treated as 1. Then go to IDLE.
- Droplet during SORT_DELAY/SORT_PULSE: no detection. Instead, count each rising edge of the gate condition in missed_cnt.
- Latency: a droplet whose last gated sample is at cycle t, with delay=0, gives sort_trig_o high at cycle t+2.
- Clearing enable forces IDLE next cycle and drops sort_trig_o. Counters are held.
- Counters wrap modulo 2^MEM. They clear via ctrl bit1, which is self-clearing and has priority over a same-cycle increment.

Bus:
- sys_ack = registered (sys_wen|sys_ren), one-cycle latency.
- sys_rdata is registered from sys_addr[19:0]; unmapped addresses read 0.
- Thresholds are sign-extended on read and take wdata[DWT-1:0] on write.
- A write takes effect the cycle after sys_wen, including mid-droplet.

Register map:
- 0x00 ctrl: bit0 enable; bit1 clear; [8+:CHN] channel mask.
- 0x04 noise thr.
- 0x08 wmin.
- 0x0C wmax.
- 0x10 delay.
- 0x14 len.
- 0x18 droplet_cnt (RO).
- 0x1C positive_cnt (RO).
- 0x20 missed_cnt (RO).
- 0x24 last_width (RO).
- 0x28 status (RO): [2:0] FSM state.
- 0x40+8k low[k].
- 0x44+8k high[k].
- 0x80+4k last_peak[k] (RO).
- Channels k>=CHN read 0 and ignore writes.

Optional Feature:
Macro FADS_TIMESTAMP_EN.
- Defined: a free-running MEM-bit cycle counter, cleared by reset and by ctrl clear. It is captured into last_ts at EVAL of every droplet, and into last_sort_ts at entry to SORT_PULSE. Readable at 0x2C and 0x30.
- Undefined: no counter is present and 0x2C/0x30 read 0.

Decomposition:
- Package fads_pkg: FSM state encoding, register address constants, default threshold/timing constants, and the CHN maximum of 4.
- Sub-module fads_peak_tracker (one instance per channel): signed running-max with load/enable inputs. The top generate-loops over CHN.

Test Plan:
- Reset mid-SORT_PULSE (adc_rst_i=1 for 1 cycle) -> next cycle sort_trig_o=0, state IDLE, all counters 0, ctrl reads 0x0000_0300 for CHN=2.
- ch0 pulse of 200 for 50 cycles, ch1=100, low=15/high=255, delay=0, len=10 -> droplet_cnt=1, positive_cnt=1, last_width=50, sort_trig_o high 10 cycles starting 2 cycles after the last gated sample.
- Same stimulus but ch1 peak=300 with mask=0b11 -> positive_cnt=0, no pulse. Repeat with mask=0b01 -> sorted.
- wmin=60 with a 50-cycle droplet -> rejected; last_width=50 still latched.
- delay=100, len=1000, second droplet 30 cycles after the first ends -> missed_cnt=1, droplet_cnt=1, a single pulse of 1000 cycles.
- Negative thresholds: noise=-100, ch0 at -50 for 5 cycles -> detected. Bus read of 0x04 returns 0xFFFF_FF9C; sys_ack is exactly one cycle after sys_ren.
